mem_lsu_initiator: RTL and testbench
====================================

// Module: mem_lsu_initiator
// PURPOSE
//  MEM-stage load/store initiator: issues data-memory requests over a valid/ready request
//  + valid response bus instead of indexing a local RAM array. Generates byte enables,
//  aligns store data and sign/zero-extends load data from funct3. Stalls the pipeline for
//  variable bus latency and drives the MEM/WB register for rd/RegWrite/MemtoReg.
// PARAMETERS
//  MAX_WAIT  255  cycles in WAIT with no response before bus_err_out is flagged (2..255)
// PORTS
//  clk              in   1   clock
//  reset            in   1   synchronous, active-high reset
//  mem_read_in      in   1   load in MEM stage
//  mem_write_in     in   1   store in MEM stage (never set together with mem_read_in)
//  funct3_in        in   3   access size/sign
//  addr_in          in   32  effective address (ALU result)
//  wdata_in         in   32  store data (rs2)
//  rd_in            in   5   destination register
//  regwrite_in      in   1   RegWrite control
//  memtoreg_in      in   1   MemtoReg control
//  stall_out        out  1   hold PC, IF/ID, ID/EX and EX/MEM
//  rd_out           out  5   MEM/WB rd
//  regwrite_out     out  1   MEM/WB RegWrite (forced 0 on fault)
//  memtoreg_out     out  1   MEM/WB MemtoReg
//  load_data_out    out  32  extended load result
//  misalign_out     out  1   one-cycle pulse: misaligned address or illegal funct3
//  bus_err_out      out  1   one-cycle pulse: bus_rsp_err or timeout
//  bus_req_valid    out  1   request valid
//  bus_req_ready    in   1   request accepted when valid & ready
//  bus_req_we       out  1   1 = write
//  bus_req_addr     out  32  word address {addr_in[31:2],2'b00}
//  bus_req_wdata    out  32  lane-replicated store data
//  bus_req_be       out  4   byte enables
//  bus_rsp_valid    in   1   response/ack valid (earliest the cycle after accept)
//  bus_rsp_rdata    in   32  read data word
//  bus_rsp_err      in   1   error qualifier on bus_rsp_valid
// BEHAVIOUR
//  Reset: state IDLE, timer 0. All registered outputs 0, incl. bus_req_valid.
//  op = mem_read_in|mem_write_in. FSM states IDLE, ISSUE, WAIT, DONE.
//  IDLE, no op: stall_out=0; MEM/WB regs load rd/regwrite/memtoreg each cycle.
//  IDLE, op illegal: funct3 in {011,110,111}, loads outside {000,001,010,100,101},
//   stores outside {000,001,010}.
//  IDLE, op misaligned: half with addr[0]=1; word with addr[1:0]!=0.
//  IDLE, op illegal or misaligned: no bus request, stall_out=0, misalign_out=1 next cycle,
//   regwrite_out=0.
//  IDLE, op legal: stall_out=1; capture bus fields; -> ISSUE.
//  ISSUE: bus_req_valid=1. addr/we/wdata/be held stable until accept. Accept -> WAIT, timer=0.
//  WAIT: timer++ per cycle. bus_rsp_valid -> capture rdata/err, -> DONE. Else
//   timer==MAX_WAIT-1 -> bus_err_out pending, -> DONE. Response and timeout in the same
//   cycle: response wins.
//  DONE: stall_out=0 (one cycle); MEM/WB regs load; load_data_out valid; -> IDLE.
//  On error/timeout: bus_err_out=1, regwrite_out=0.
//  stall_out=1 in ISSUE and WAIT. stall_out=1 in IDLE only for a legal op.
//  Minimum op latency: 3 stall cycles (ready and rsp both immediate).
//  Store BE: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
//  Store wdata: {4{b}} / {2{h}} / w.
//  Load extract: lane = rdata >> (8*addr[1:0]). LB/LH sign-extend; LBU/LHU zero-extend;
//   LW pass-through.
//  bus_rsp_valid outside WAIT is ignored. Writes wait for an ack like reads.
//  Reset mid-transaction: -> IDLE next edge, bus_req_valid drops.
//   The bus discards an outstanding request on reset.
// STRUCTURE
//  riscv_mem_pkg: funct3 codes (LB..SW), FSM state encoding, MAX_WAIT width constant.
//  Sub-module lsu_align (combinational): be, wdata replication, load extraction,
//   misalign/illegal detect.
// TESTING
//  SW addr 0x100, data 0xDEADBEEF, ready=1, ack next -> be=1111, addr=0x100,
//   stall 3 cycles, regwrite_out=0.
//  SB addr 0x103, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5.
//  LB addr 0x102, rdata 0x1280FF00 -> load_data_out=0xFFFFFF80.
//  LBU at the same address -> 0x00000080.
//  LH addr 0x101 -> no bus_req_valid, misalign_out pulse, regwrite_out=0, stall_out never 1.
//  LW, ready low 4 cycles then rsp after 2 -> addr/be stable while waiting; stall_out=1
//   throughout; result 1 cycle after rsp.
//  LW with no rsp, MAX_WAIT=4 -> bus_err_out after 4 WAIT cycles.
//  Reset asserted in WAIT -> state IDLE, all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_lsu_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_lsu_initiator_pkg
// Brief  : funct3 access codes, LSU FSM state encoding and timer width.
// Rev    : 1.0 - initial release
// ============================================================================
package mem_lsu_initiator_pkg;

  localparam logic [2:0] c_f3_lb  = 3'b000;
  localparam logic [2:0] c_f3_lh  = 3'b001;
  localparam logic [2:0] c_f3_lw  = 3'b010;
  localparam logic [2:0] c_f3_lbu = 3'b100;
  localparam logic [2:0] c_f3_lhu = 3'b101;
  localparam logic [2:0] c_f3_sb  = 3'b000;
  localparam logic [2:0] c_f3_sh  = 3'b001;
  localparam logic [2:0] c_f3_sw  = 3'b010;

  // Wide enough for MAX_WAIT up to 255
  localparam int c_timer_w = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lsu_initiator_if.sv
`default_nettype none
// ============================================================================
// Module : mem_lsu_initiator_if
// Brief  : Data-memory request/response bus (valid/ready request, valid response).
// Rev    : 1.0 - initial release
// ============================================================================
interface mem_lsu_initiator_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_we;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_be;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_err;

  modport master (
    output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_be,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );

  modport slave (
    input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_be,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_lsu_initiator_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_align
// Brief  : Byte enables, store lane replication, fault detect and load extraction.
// Rev    : 1.0 - initial release
// ============================================================================
module lsu_align
  import mem_lsu_initiator_pkg::*;
(
  input  logic [2:0]  i_req_funct3,
  input  logic [1:0]  i_req_off,
  input  logic        i_req_store,
  input  logic [31:0] i_req_wdata,
  output logic [3:0]  o_req_be,
  output logic [31:0] o_req_wdata,
  output logic        o_req_fault,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic        w_misalign;
  logic        w_illegal;
  logic [31:0] w_lane;

  always_comb begin
    o_req_be    = 4'b1111;
    o_req_wdata = i_req_wdata;
    w_misalign  = 1'b0;
    case (i_req_funct3[1:0])
      2'b00: begin
        o_req_be    = 4'b0001 << i_req_off;
        o_req_wdata = {4{i_req_wdata[7:0]}};
      end
      2'b01: begin
        o_req_be    = 4'b0011 << i_req_off;
        o_req_wdata = {2{i_req_wdata[15:0]}};
        w_misalign  = i_req_off[0];
      end
      default: w_misalign = |i_req_off;
    endcase
  end

  // Size code 11 and LWU are never legal; stores have no unsigned variants
  assign w_illegal = (i_req_funct3[1:0] == 2'b11) || (i_req_funct3 == 3'b110) ||
                     (i_req_store && i_req_funct3[2]);
  assign o_req_fault = w_illegal || w_misalign;

  assign w_lane = i_ld_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    o_ld_data = w_lane;
    case (i_ld_funct3)
      c_f3_lb:  o_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
      c_f3_lh:  o_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
      c_f3_lbu: o_ld_data = {24'b0, w_lane[7:0]};
      c_f3_lhu: o_ld_data = {16'b0, w_lane[15:0]};
      default:  o_ld_data = w_lane;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu_initiator.sv
`default_nettype none
// ============================================================================
// Module : mem_lsu_initiator
// Brief  : MEM-stage load/store initiator over a valid/ready bus with stall control.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_lsu_initiator
  import mem_lsu_initiator_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_read_in,
  input  logic                       mem_write_in,
  input  logic [2:0]                 funct3_in,
  input  logic [31:0]                addr_in,
  input  logic [31:0]                wdata_in,
  input  logic [4:0]                 rd_in,
  input  logic                       regwrite_in,
  input  logic                       memtoreg_in,
  output logic                       stall_out,
  output logic [4:0]                 rd_out,
  output logic                       regwrite_out,
  output logic                       memtoreg_out,
  output logic [31:0]                load_data_out,
  output logic                       misalign_out,
  output logic                       bus_err_out,
  mem_lsu_initiator_if.master        bus
);

  localparam logic [c_timer_w-1:0] c_timeout = c_timer_w'(MAX_WAIT - 1);

  lsu_state_t            r_state;
  lsu_state_t            w_next;
  logic                  r_req_valid;
  logic                  r_req_we;
  logic [31:0]           r_req_addr;
  logic [31:0]           r_req_wdata;
  logic [3:0]            r_req_be;
  logic [2:0]            r_funct3;
  logic [1:0]            r_off;
  logic [4:0]            r_rd;
  logic                  r_regwrite;
  logic                  r_memtoreg;
  logic [c_timer_w-1:0]  r_timer;

  logic                  w_op;
  logic                  w_fault;
  logic                  w_accept;
  logic                  w_timeout;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_ld_data;

  assign w_op      = mem_read_in || mem_write_in;
  assign w_accept  = r_req_valid && bus.bus_req_ready;
  assign w_timeout = (r_timer == c_timeout);

  lsu_align u_align (
    .i_req_funct3 (funct3_in),
    .i_req_off    (addr_in[1:0]),
    .i_req_store  (mem_write_in),
    .i_req_wdata  (wdata_in),
    .o_req_be     (w_be),
    .o_req_wdata  (w_wdata),
    .o_req_fault  (w_fault),
    .i_ld_funct3  (r_funct3),
    .i_ld_off     (r_off),
    .i_ld_rdata   (bus.bus_rsp_rdata),
    .o_ld_data    (w_ld_data)
  );

  assign bus.bus_req_valid = r_req_valid;
  assign bus.bus_req_we    = r_req_we;
  assign bus.bus_req_addr  = r_req_addr;
  assign bus.bus_req_wdata = r_req_wdata;
  assign bus.bus_req_be    = r_req_be;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    stall_out = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_op && !w_fault) begin
          stall_out = 1'b1;
          w_next    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        stall_out = 1'b1;
        if (w_accept) w_next = S_WAIT;
      end
      S_WAIT: begin
        stall_out = 1'b1;
        if (bus.bus_rsp_valid || w_timeout) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_valid   <= 1'b0;
      r_req_we      <= 1'b0;
      r_req_addr    <= '0;
      r_req_wdata   <= '0;
      r_req_be      <= '0;
      r_funct3      <= '0;
      r_off         <= '0;
      r_rd          <= '0;
      r_regwrite    <= 1'b0;
      r_memtoreg    <= 1'b0;
      r_timer       <= '0;
      rd_out        <= '0;
      regwrite_out  <= 1'b0;
      memtoreg_out  <= 1'b0;
      load_data_out <= '0;
      misalign_out  <= 1'b0;
      bus_err_out   <= 1'b0;
    end else begin
      misalign_out <= 1'b0;
      bus_err_out  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_op || w_fault) begin
            rd_out       <= rd_in;
            regwrite_out <= regwrite_in && !w_op;
            memtoreg_out <= memtoreg_in;
            misalign_out <= w_op;
          end else begin
            r_req_valid <= 1'b1;
            r_req_we    <= mem_write_in;
            r_req_addr  <= {addr_in[31:2], 2'b00};
            r_req_wdata <= w_wdata;
            r_req_be    <= w_be;
            r_funct3    <= funct3_in;
            r_off       <= addr_in[1:0];
            r_rd        <= rd_in;
            r_regwrite  <= regwrite_in;
            r_memtoreg  <= memtoreg_in;
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_req_valid <= 1'b0;
            r_timer     <= '0;
          end
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          // MEM/WB is loaded on leaving WAIT so the result is visible during DONE
          if (bus.bus_rsp_valid) begin
            rd_out        <= r_rd;
            memtoreg_out  <= r_memtoreg;
            regwrite_out  <= r_regwrite && !bus.bus_rsp_err;
            load_data_out <= bus.bus_rsp_err ? 32'h0 : w_ld_data;
            bus_err_out   <= bus.bus_rsp_err;
          end else if (w_timeout) begin
            rd_out        <= r_rd;
            memtoreg_out  <= r_memtoreg;
            regwrite_out  <= 1'b0;
            load_data_out <= 32'h0;
            bus_err_out   <= 1'b1;
          end
        end
        S_DONE: regwrite_out <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu_initiator.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_lsu_initiator
// Brief  : Table-driven, directed and randomized checks of the MEM-stage LSU.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu_initiator;

  localparam int c_max_wait = 4;

  logic        clk;
  logic        reset;
  logic        mem_read_in, mem_write_in, regwrite_in, memtoreg_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, wdata_in;
  logic [4:0]  rd_in;
  logic        stall_out, regwrite_out, memtoreg_out, misalign_out, bus_err_out;
  logic [4:0]  rd_out;
  logic [31:0] load_data_out;

  int n_checks = 0;
  int n_err    = 0;

  mem_lsu_initiator_if bus ();

  mem_lsu_initiator #(.MAX_WAIT(c_max_wait)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .funct3_in     (funct3_in),
    .addr_in       (addr_in),
    .wdata_in      (wdata_in),
    .rd_in         (rd_in),
    .regwrite_in   (regwrite_in),
    .memtoreg_in   (memtoreg_in),
    .stall_out     (stall_out),
    .rd_out        (rd_out),
    .regwrite_out  (regwrite_out),
    .memtoreg_out  (memtoreg_out),
    .load_data_out (load_data_out),
    .misalign_out  (misalign_out),
    .bus_err_out   (bus_err_out),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          ld;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    bit          rw;
    bit          m2r;
    int          rdy;
    int          rsp;
    logic [31:0] rdata;
    bit          err;
    bit          nrsp;
    bit          x_fault;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
    logic [31:0] x_ld;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    funct3_in    = 3'b000;
    addr_in      = 32'h0;
    wdata_in     = 32'h0;
    rd_in        = 5'd0;
    regwrite_in  = 1'b0;
    memtoreg_in  = 1'b0;
  endtask

  // Reference model: access rules expressed as sizes and plain arithmetic
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int          size, off;
    bit          legal;
    logic [31:0] lane;
    r     = v;
    size  = 1 << v.f3[1:0];
    off   = int'(v.addr[1:0]);
    legal = v.ld ? (v.f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                 : (v.f3 inside {3'b000, 3'b001, 3'b010});
    r.x_fault = !legal || ((off % size) != 0);
    r.x_be    = 4'(((1 << size) - 1) << off);
    if (size == 1)      r.x_wdata = 32'(v.wdata[7:0]) * 32'h01010101;
    else if (size == 2) r.x_wdata = 32'(v.wdata[15:0]) * 32'h00010001;
    else                r.x_wdata = v.wdata;
    lane = v.rdata >> (8 * off);
    if (size == 1) begin
      lane = lane & 32'hFF;
      if (!v.f3[2] && lane >= 32'h80) lane = lane - 32'h100;
    end else if (size == 2) begin
      lane = lane & 32'hFFFF;
      if (!v.f3[2] && lane >= 32'h8000) lane = lane - 32'h10000;
    end
    r.x_ld = lane;
    return r;
  endfunction

  // Pass-through cycle in IDLE; a stray response here must be ignored
  task automatic nop_cycle(input logic [4:0] rd, input bit rw, input bit m2r, input bit noise);
    drive_idle();
    rd_in = rd; regwrite_in = rw; memtoreg_in = m2r;
    bus.bus_rsp_valid = noise; bus.bus_rsp_err = noise;
    #1;
    chk("nop_stall", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    chk("nop_rd", 32'(rd_out), 32'(rd));
    chk("nop_regwrite", 32'(regwrite_out), 32'(rw));
    chk("nop_memtoreg", 32'(memtoreg_out), 32'(m2r));
    chk("nop_noise_err", 32'(bus_err_out), 32'd0);
    chk("nop_req_valid", 32'(bus.bus_req_valid), 32'd0);
    bus.bus_rsp_valid = 1'b0; bus.bus_rsp_err = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    int stalls, nwait;
    bit bad;
    mem_read_in = v.ld; mem_write_in = v.st; funct3_in = v.f3;
    addr_in = v.addr; wdata_in = v.wdata; rd_in = v.rd;
    regwrite_in = v.rw; memtoreg_in = v.m2r;
    #1;
    if (v.x_fault) begin
      chk("fault_stall", 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      chk("fault_pulse", 32'(misalign_out), 32'd1);
      chk("fault_regwrite", 32'(regwrite_out), 32'd0);
      chk("fault_rd", 32'(rd_out), 32'(v.rd));
      chk("fault_req_valid", 32'(bus.bus_req_valid), 32'd0);
      drive_idle();
      @(posedge clk); #1;
      chk("fault_pulse_end", 32'(misalign_out), 32'd0);
      return;
    end
    stalls = 0;
    if (stall_out) stalls++;
    @(posedge clk); #1;
    for (int i = 0; i <= v.rdy; i++) begin
      bus.bus_req_ready = (i == v.rdy);
      #1;
      if (stall_out) stalls++;
      chk("req_valid", 32'(bus.bus_req_valid), 32'd1);
      chk("req_addr", bus.bus_req_addr, v.addr & 32'hFFFF_FFFC);
      chk("req_we", 32'(bus.bus_req_we), 32'(v.st));
      if (v.st) begin
        chk("req_be", 32'(bus.bus_req_be), 32'(v.x_be));
        chk("req_wdata", bus.bus_req_wdata, v.x_wdata);
      end
      @(posedge clk); #1;
    end
    bus.bus_req_ready = 1'b0;
    nwait = v.nrsp ? c_max_wait : v.rsp + 1;
    for (int j = 0; j < nwait; j++) begin
      bus.bus_rsp_valid = !v.nrsp && (j == v.rsp);
      bus.bus_rsp_rdata = v.rdata;
      bus.bus_rsp_err   = v.err;
      #1;
      if (stall_out) stalls++;
      if (j == 0) chk("wait_req_valid", 32'(bus.bus_req_valid), 32'd0);
      @(posedge clk); #1;
    end
    bus.bus_rsp_valid = 1'b0; bus.bus_rsp_err = 1'b0;
    bad = v.nrsp || v.err;
    chk("done_stall", 32'(stall_out), 32'd0);
    chk("stall_cycles", 32'(stalls), 32'(2 + v.rdy + nwait));
    chk("done_bus_err", 32'(bus_err_out), 32'(bad));
    chk("done_regwrite", 32'(regwrite_out), 32'(v.rw && !bad));
    chk("done_rd", 32'(rd_out), 32'(v.rd));
    chk("done_memtoreg", 32'(memtoreg_out), 32'(v.m2r));
    if (v.ld && !bad) chk("done_load_data", load_data_out, v.x_ld);
    @(posedge clk); #1;
    drive_idle();
    #1;
    chk("idle_bus_err", 32'(bus_err_out), 32'd0);
    chk("idle_req_valid", 32'(bus.bus_req_valid), 32'd0);
    chk("idle_stall", 32'(stall_out), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //           ld st f3      addr          wdata         rd  rw m2r rdy rsp rdata          err nrsp flt be      wdata          load
    tbl[0]  = '{0, 1, 3'b010, 32'h100,      32'hDEADBEEF, 5'd0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{0, 1, 3'b000, 32'h103,      32'h000000A5, 5'd0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0};
    tbl[2]  = '{1, 0, 3'b000, 32'h102,      32'h0,        5'd5, 1, 1, 0, 0, 32'h1280FF00,   0, 0, 0, 4'b0,    32'h0,        32'hFFFFFF80};
    tbl[3]  = '{1, 0, 3'b100, 32'h102,      32'h0,        5'd6, 1, 1, 1, 1, 32'h1280FF00,   0, 0, 0, 4'b0,    32'h0,        32'h00000080};
    tbl[4]  = '{1, 0, 3'b001, 32'h101,      32'h0,        5'd7, 1, 1, 0, 0, 32'h0,          0, 0, 1, 4'b0,    32'h0,        32'h0};
    tbl[5]  = '{1, 0, 3'b010, 32'h200,      32'h0,        5'd8, 1, 1, 4, 2, 32'hCAFEF00D,   0, 0, 0, 4'b0,    32'h0,        32'hCAFEF00D};
    tbl[6]  = '{1, 0, 3'b010, 32'h300,      32'h0,        5'd9, 1, 1, 0, 0, 32'h0,          0, 1, 0, 4'b0,    32'h0,        32'h0};
    tbl[7]  = '{1, 0, 3'b001, 32'h102,      32'h0,        5'd10, 1, 1, 0, 0, 32'h80001234,  0, 0, 0, 4'b0,    32'h0,        32'hFFFF8000};
    tbl[8]  = '{1, 0, 3'b101, 32'h102,      32'h0,        5'd11, 1, 1, 2, 0, 32'h80001234,  0, 0, 0, 4'b0,    32'h0,        32'h00008000};
    tbl[9]  = '{0, 1, 3'b001, 32'h102,      32'h1234ABCD, 5'd0, 0, 0, 0, 1, 32'h0,          0, 0, 0, 4'b1100, 32'hABCDABCD, 32'h0};
    tbl[10] = '{1, 0, 3'b010, 32'h400,      32'h0,        5'd12, 1, 1, 0, 1, 32'h11111111,  1, 0, 0, 4'b0,    32'h0,        32'h0};
    tbl[11] = '{1, 0, 3'b011, 32'h0,        32'h0,        5'd13, 1, 1, 0, 0, 32'h0,         0, 0, 1, 4'b0,    32'h0,        32'h0};
    tbl[12] = '{0, 1, 3'b100, 32'h0,        32'h0,        5'd0, 0, 0, 0, 0, 32'h0,          0, 0, 1, 4'b0,    32'h0,        32'h0};
    tbl[13] = '{1, 0, 3'b010, 32'h500,      32'h0,        5'd14, 1, 1, 0, 3, 32'h0BADCAFE,  0, 0, 0, 4'b0,    32'h0,        32'h0BADCAFE};
    tbl[14] = '{1, 0, 3'b010, 32'h102,      32'h0,        5'd15, 1, 1, 0, 0, 32'h0,         0, 0, 1, 4'b0,    32'h0,        32'h0};

    reset = 1'b1;
    drive_idle();
    bus.bus_req_ready = 1'b0; bus.bus_rsp_valid = 1'b0;
    bus.bus_rsp_rdata = 32'h0; bus.bus_rsp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(bus.bus_req_valid), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_regwrite", 32'(regwrite_out), 32'd0);
    chk("rst_load_data", load_data_out, 32'd0);
    chk("rst_pulses", {30'd0, misalign_out, bus_err_out}, 32'd0);
    reset = 1'b0;

    nop_cycle(5'd3, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) run_op(tbl[i]);

    // Reset while waiting for a response
    nop_cycle(5'd9, 1'b1, 1'b1, 1'b0);
    mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h40;
    rd_in = 5'd4; regwrite_in = 1'b1; memtoreg_in = 1'b1;
    @(posedge clk); #1;
    bus.bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.bus_req_ready = 1'b0;
    chk("rstw_in_wait", 32'(stall_out), 32'd1);
    reset = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    chk("rstw_req_valid", 32'(bus.bus_req_valid), 32'd0);
    chk("rstw_stall", 32'(stall_out), 32'd0);
    chk("rstw_rd", 32'(rd_out), 32'd0);
    chk("rstw_regwrite", 32'(regwrite_out), 32'd0);
    chk("rstw_memtoreg", 32'(memtoreg_out), 32'd0);
    chk("rstw_load_data", load_data_out, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rstw_stays_idle", 32'(bus.bus_req_valid), 32'd0);

    // Randomized accesses against the reference model
    for (int k = 0; k < 60; k++) begin
      int pick, size;
      v.ld = ($urandom_range(0, 1) == 1);
      v.st = !v.ld;
      if ($urandom_range(0, 4) == 0) v.f3 = 3'($urandom_range(0, 7));
      else if (v.ld) begin
        pick = $urandom_range(0, 4);
        v.f3 = (pick < 3) ? 3'(pick) : 3'(pick + 1);
      end else v.f3 = 3'($urandom_range(0, 2));
      v.addr = $urandom;
      size = 1 << v.f3[1:0];
      if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~32'(size - 1);
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.rd    = 5'($urandom);
      v.rw    = v.ld && ($urandom_range(0, 3) != 0);
      v.m2r   = v.ld;
      v.rdy   = $urandom_range(0, 3);
      v.rsp   = $urandom_range(0, c_max_wait - 1);
      v.err   = ($urandom_range(0, 7) == 0);
      v.nrsp  = ($urandom_range(0, 9) == 0);
      v = model(v);
      if ($urandom_range(0, 2) == 0)
        nop_cycle(5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      run_op(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
